immediate_extension_unit: RTL and testbench
===========================================

Name: immediate_extension_unit

Overview:
- Registered immediate-extension stage for the decode path: widens an N-bit instruction immediate to the M-bit datapath width.
- Supports zero extension (U=1) or sign extension (U=0), with optional placement modes: plain, word-offset shift, and upper-half load.
- Output is registered, with one-cycle latency and a valid flag. It feeds the ALU operand mux and the branch-target adder.

Parameters:
- N, 16, input immediate width; legal range 2 ≤ N < M.
- M, 32, output width; elaboration error (generate-time check) if N ≥ M.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies immediateIN, U and mode this cycle.
- immediateIN  input  N  raw immediate field.
- U  input  1  1 = zero (unsigned) extension, 0 = sign extension.
- mode  input  2  placement select (see Behaviour).
- immediateOUT  output  M  extended/placed immediate, registered.
- out_valid  output  1  immediateOUT holds a result computed from an in_valid cycle.

Behaviour:
- All state updates on the rising clk edge only; reset is sampled on that edge (no asynchronous path).
- Reset (rst_n=0 at an edge): immediateOUT ← 0, out_valid ← 0. Reset dominates in_valid in the same cycle.
- Reset deasserting mid-stream: the first capture happens on the first edge with rst_n=1 and in_valid=1.
- Latency: inputs sampled at edge k with in_valid=1 appear on immediateOUT after edge k, and out_valid=1 after edge k.
- in_valid=0 at an edge: out_valid ← 0, and immediateOUT holds its previous value (no toggle on idle cycles).
- No backpressure: a new result is accepted every cycle, and back-to-back in_valid gives back-to-back out_valid.
- Extension, E (M bits):
  - U=1: E = {(M−N) zeros, immediateIN}.
  - U=0: E = {(M−N) copies of immediateIN[N−1], immediateIN}.
- Mode encoding:
  - 2'b00 EXT: result = E.
  - 2'b01 EXT_SHL2: result = E << 2, truncated to M bits. Bits shifted out of the top are discarded and no flag is raised.
  - 2'b10 UPPER: result = {immediateIN, (M−N) zeros}. U is ignored.
  - 2'b11 reserved: behaves exactly as EXT.
- Purely unsigned/bitwise logic: no arithmetic beyond the shift, and no X propagation from U when mode=UPPER.
- Unknown or X inputs are not required to be handled while in_valid=0.

Decomposition:
- Shared package imm_ext_pkg holds:
  - the mode constants IMM_MODE_EXT=2'b00, IMM_MODE_SHL2=2'b01, IMM_MODE_UPPER=2'b10, IMM_MODE_RSVD=2'b11;
  - a 2-bit mode typedef.
- One combinational sub-module, imm_ext_core (parameters N, M; ports immediateIN, U, mode → result). It is instantiated once.
- The top adds the output register, valid flag and parameter check.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and immediateIN=16'hFFFF → immediateOUT=32'h0, out_valid=0. Release, then on the next valid edge the output updates.
- EXT zero/sign: each input is applied with in_valid=1, mode=00, and checked one cycle later.
  - U=1, 16'h000A → 32'h0000000A.
  - U=0, 16'h800A → 32'hFFFF800A.
  - U=1, 16'h1E1F → 32'h00001E1F.
  - U=0, 16'hFE1F → 32'hFFFFFE1F.
  - U=1, 16'h800A → 32'h0000800A.
- EXT_SHL2: U=0, 16'hFFFF → 32'hFFFFFFFC. U=1, 16'hC001 → 32'h00030004. U=0, 16'h8000 → 32'hFFFE0000.
- UPPER and reserved:
  - mode=10, 16'h1234 with U=0 → 32'h12340000; same result with U=1.
  - mode=11, U=0, 16'h8001 → 32'hFFFF8001.
- Valid/hold: issue 3 back-to-back valid inputs, then in_valid=0 for 2 cycles.
  - out_valid is 1,1,1,0,0.
  - immediateOUT holds the third result during the idle cycles.
  - Assert rst_n=0 mid-stream → outputs go to 0 on that edge.
- Parameter sweep: N=12, M=32, U=0, 12'h800 → 32'hFFFFF800. N=8, M=16, U=1, 8'hFF → 16'h00FF.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared placement-mode encoding for the immediate-extension stage.
package imm_ext_pkg;

  typedef logic [1:0] imm_mode_t;

  localparam imm_mode_t IMM_MODE_EXT   = 2'b00;
  localparam imm_mode_t IMM_MODE_SHL2  = 2'b01;
  localparam imm_mode_t IMM_MODE_UPPER = 2'b10;
  localparam imm_mode_t IMM_MODE_RSVD  = 2'b11;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational widening of an N-bit immediate to M bits with zero/sign
// extension and EXT / EXT<<2 / UPPER placement.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 32
) (
  input  logic [N-1:0] immediateIN,
  input  logic         U,
  input  imm_mode_t    mode,
  output logic [M-1:0] result
);

  localparam int unsigned PAD = M - N;

  logic         w_fill;
  logic [M-1:0] w_ext;
  logic [M-1:0] w_shl2;
  logic [M-1:0] w_upper;

  // Fill bit is forced to 0 for zero extension, independent of the MSB.
  assign w_fill  = ~U & immediateIN[N-1];
  assign w_ext   = {{PAD{w_fill}}, immediateIN};
  assign w_shl2  = w_ext << 2;
  assign w_upper = {immediateIN, {PAD{1'b0}}};

  // UPPER does not depend on U at all; reserved encoding falls back to EXT.
  always_comb begin
    result = w_ext;
    case (mode)
      IMM_MODE_EXT:   result = w_ext;
      IMM_MODE_SHL2:  result = w_shl2;
      IMM_MODE_UPPER: result = w_upper;
      IMM_MODE_RSVD:  result = w_ext;
      default:        result = w_ext;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/immediate_extension_unit.sv
// Registered immediate-extension stage: one-cycle latency, valid flag,
// output data held on idle cycles.
module immediate_extension_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] immediateIN,
  input  logic         U,
  input  imm_mode_t    mode,
  output logic [M-1:0] immediateOUT,
  output logic         out_valid
);

  generate
    if (N >= M) begin : g_bad_width
      $error("immediate_extension_unit: N (%0d) must be less than M (%0d)", N, M);
    end
    if (N < 2) begin : g_bad_n
      $error("immediate_extension_unit: N (%0d) must be at least 2", N);
    end
  endgenerate

  logic [M-1:0] w_result;
  logic [M-1:0] r_out;
  logic         r_valid;

  imm_ext_core #(
    .N (N),
    .M (M)
  ) u_core (
    .immediateIN (immediateIN),
    .U           (U),
    .mode        (mode),
    .result      (w_result)
  );

  // Reset wins over in_valid; data only loads on valid cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_result;
      end
    end
  end

  assign immediateOUT = r_out;
  assign out_valid    = r_valid;

endmodule : immediate_extension_unit

// File: tb/tb_immediate_extension_unit.sv
// Directed, table-driven bench for immediate_extension_unit, including two
// extra instances at other N/M widths.
module tb_immediate_extension_unit;
  import imm_ext_pkg::*;

  logic clk;
  logic rst_n;

  logic        in_valid;
  logic [15:0] imm;
  logic        u;
  imm_mode_t   mode;
  logic [31:0] out;
  logic        out_valid;

  logic        in_valid_12;
  logic [11:0] imm_12;
  logic        u_12;
  imm_mode_t   mode_12;
  logic [31:0] out_12;
  logic        out_valid_12;

  logic        in_valid_8;
  logic [7:0]  imm_8;
  logic        u_8;
  imm_mode_t   mode_8;
  logic [15:0] out_8;
  logic        out_valid_8;

  int errors = 0;
  int checks = 0;

  immediate_extension_unit #(.N(16), .M(32)) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .immediateIN (imm),
    .U (u), .mode (mode), .immediateOUT (out), .out_valid (out_valid)
  );

  immediate_extension_unit #(.N(12), .M(32)) dut12 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid_12), .immediateIN (imm_12),
    .U (u_12), .mode (mode_12), .immediateOUT (out_12), .out_valid (out_valid_12)
  );

  immediate_extension_unit #(.N(8), .M(16)) dut8 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid_8), .immediateIN (imm_8),
    .U (u_8), .mode (mode_8), .immediateOUT (out_8), .out_valid (out_valid_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        u;
    imm_mode_t   mode;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic uu, input imm_mode_t md, input logic [15:0] x);
    @(negedge clk);
    in_valid = v;
    u        = uu;
    mode     = md;
    imm      = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"ext_u_000A",  1'b1, IMM_MODE_EXT,   16'h000A, 32'h0000000A};
    vecs[1]  = '{"ext_s_800A",  1'b0, IMM_MODE_EXT,   16'h800A, 32'hFFFF800A};
    vecs[2]  = '{"ext_u_1E1F",  1'b1, IMM_MODE_EXT,   16'h1E1F, 32'h00001E1F};
    vecs[3]  = '{"ext_s_FE1F",  1'b0, IMM_MODE_EXT,   16'hFE1F, 32'hFFFFFE1F};
    vecs[4]  = '{"ext_u_800A",  1'b1, IMM_MODE_EXT,   16'h800A, 32'h0000800A};
    vecs[5]  = '{"shl2_s_FFFF", 1'b0, IMM_MODE_SHL2,  16'hFFFF, 32'hFFFFFFFC};
    vecs[6]  = '{"shl2_u_C001", 1'b1, IMM_MODE_SHL2,  16'hC001, 32'h00030004};
    vecs[7]  = '{"shl2_s_8000", 1'b0, IMM_MODE_SHL2,  16'h8000, 32'hFFFE0000};
    vecs[8]  = '{"upper_s",     1'b0, IMM_MODE_UPPER, 16'h1234, 32'h12340000};
    vecs[9]  = '{"upper_u",     1'b1, IMM_MODE_UPPER, 16'h1234, 32'h12340000};
    vecs[10] = '{"rsvd_s_8001", 1'b0, IMM_MODE_RSVD,  16'h8001, 32'hFFFF8001};

    rst_n = 1'b0;
    in_valid = 1'b1; imm = 16'hFFFF; u = 1'b0; mode = IMM_MODE_EXT;
    in_valid_12 = 1'b0; imm_12 = '0; u_12 = 1'b0; mode_12 = IMM_MODE_EXT;
    in_valid_8 = 1'b0; imm_8 = '0; u_8 = 1'b0; mode_8 = IMM_MODE_EXT;

    // Reset held for two edges while in_valid=1 must keep outputs at zero.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, IMM_MODE_EXT, 16'h0042);
    check("post_reset_out", out, 32'h00000042);
    check("post_reset_valid", 32'(out_valid), 32'h1);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].u, vecs[i].mode, vecs[i].imm);
      check(vecs[i].name, out, vecs[i].exp);
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'h1);
    end

    // Back-to-back results, then idle cycles hold the last data.
    drive(1'b1, 1'b1, IMM_MODE_EXT,  16'h0001);
    check("b2b0_valid", 32'(out_valid), 32'h1);
    drive(1'b1, 1'b0, IMM_MODE_SHL2, 16'h0003);
    check("b2b1_out", out, 32'h0000000C);
    check("b2b1_valid", 32'(out_valid), 32'h1);
    drive(1'b1, 1'b0, IMM_MODE_EXT,  16'hA5A5);
    check("b2b2_out", out, 32'hFFFFA5A5);
    check("b2b2_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 1'b1, IMM_MODE_UPPER, 16'h7777);
    check("idle0_out", out, 32'hFFFFA5A5);
    check("idle0_valid", 32'(out_valid), 32'h0);
    drive(1'b0, 1'b0, IMM_MODE_EXT, 16'h0000);
    check("idle1_out", out, 32'hFFFFA5A5);
    check("idle1_valid", 32'(out_valid), 32'h0);

    // Mid-stream reset clears both outputs on the edge it is sampled.
    drive(1'b1, 1'b1, IMM_MODE_EXT, 16'h1111);
    check("pre_rst_out", out, 32'h00001111);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; imm = 16'h2222;
    @(posedge clk); #1;
    check("mid_rst_out", out, 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Other widths.
    @(negedge clk);
    in_valid_12 = 1'b1; u_12 = 1'b0; mode_12 = IMM_MODE_EXT; imm_12 = 12'h800;
    in_valid_8  = 1'b1; u_8  = 1'b1; mode_8  = IMM_MODE_EXT; imm_8  = 8'hFF;
    @(posedge clk); #1;
    check("n12_ext_s_800", out_12, 32'hFFFFF800);
    check("n12_valid", 32'(out_valid_12), 32'h1);
    check("n8_ext_u_FF", 32'(out_8), 32'h000000FF);
    check("n8_valid", 32'(out_valid_8), 32'h1);
    @(negedge clk);
    u_12 = 1'b1; mode_12 = IMM_MODE_UPPER; imm_12 = 12'hABC;
    u_8  = 1'b0; mode_8  = IMM_MODE_SHL2;  imm_8  = 8'h80;
    @(posedge clk); #1;
    check("n12_upper_ABC", out_12, 32'hABC00000);
    check("n8_shl2_s_80", 32'(out_8), 32'h0000FE00);
    @(negedge clk);
    in_valid_12 = 1'b0; in_valid_8 = 1'b0;
    @(posedge clk); #1;
    check("n8_idle_hold", 32'(out_8), 32'h0000FE00);
    check("n8_idle_valid", 32'(out_valid_8), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_immediate_extension_unit
